// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - multi-item vending controller with price table, credit ceiling and serial change
module vend_ctrl_param #(
   parameter int N_ITEMS    = 4,
   parameter int CREDIT_W   = 8,
   parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES = {8'd6, 8'd5, 8'd4, 8'd3},
   parameter int MAX_CREDIT = 12,
   localparam int SEL_W     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_coin_valid,
   input  logic [1:0]          i_coin_type,
   input  logic                i_sel_valid,
   input  logic [SEL_W-1:0]    i_sel_id,
   input  logic                i_cancel,
   output logic                o_coin_reject,
   output logic                o_sel_short,
   output logic                o_vend_valid,
   output logic [SEL_W-1:0]    o_vend_id,
   output logic                o_chg5,
   output logic                o_busy,
   output logic [CREDIT_W-1:0] o_credit
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CREDIT = 2'd1;
   localparam logic [1:0] S_VEND   = 2'd2;
   localparam logic [1:0] S_CHANGE = 2'd3;

   logic [1:0]          r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] r_refund;
   logic [SEL_W-1:0]    r_vend_id;
   logic                r_coin_reject;
   logic                r_sel_short;
   logic                r_vend_valid;
   logic                r_chg5;
   logic                r_busy;

   logic [1:0]          w_state_nx;
   logic [CREDIT_W-1:0] w_credit_nx;
   logic [CREDIT_W-1:0] w_refund_nx;
   logic [SEL_W-1:0]    w_vend_id_nx;
   logic                w_coin_reject;
   logic                w_sel_short;
   logic                w_vend;
   logic [CREDIT_W:0]   w_coin_val;
   logic [CREDIT_W:0]   w_sum;
   logic                w_coin_ok;
   logic                w_sel_in_range;
   logic [CREDIT_W-1:0] w_price;
   logic [CREDIT_W-1:0] w_price_tab [N_ITEMS];

   genvar gi;
   generate
      for (gi = 0; gi < N_ITEMS; gi++) begin : g_price
         assign w_price_tab[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
      end
   endgenerate

   always_comb begin
      w_coin_val = '0;
      case (i_coin_type)
         2'b00:   w_coin_val = (CREDIT_W+1)'(1);
         2'b01:   w_coin_val = (CREDIT_W+1)'(2);
         2'b10:   w_coin_val = (CREDIT_W+1)'(4);
         default: w_coin_val = '0;
      endcase
   end

   // Sum is one bit wider so the ceiling compare cannot be fooled by a wrap
   assign w_sum          = {1'b0, r_credit} + w_coin_val;
   assign w_coin_ok      = (i_coin_type != 2'b11) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
   assign w_sel_in_range = 32'(i_sel_id) < N_ITEMS;
   assign w_price        = w_sel_in_range ? w_price_tab[i_sel_id] : '0;

   always_comb begin
      w_state_nx    = r_state;
      w_credit_nx   = r_credit;
      w_refund_nx   = r_refund;
      w_vend_id_nx  = r_vend_id;
      w_coin_reject = 1'b0;
      w_sel_short   = 1'b0;
      w_vend        = 1'b0;
      case (r_state)
         S_IDLE, S_CREDIT: begin
            if (r_state == S_CREDIT && i_cancel) begin
               w_refund_nx   = r_credit;
               w_credit_nx   = '0;
               w_state_nx    = S_CHANGE;
               w_coin_reject = i_coin_valid;
            end else if (r_state == S_CREDIT && i_sel_valid && w_sel_in_range
                         && r_credit >= w_price) begin
               w_vend        = 1'b1;
               w_vend_id_nx  = i_sel_id;
               w_refund_nx   = r_credit - w_price;
               w_credit_nx   = '0;
               w_state_nx    = S_VEND;
               w_coin_reject = i_coin_valid;
            end else begin
               // A short or ignored selection does not block a coin in the same cycle
               if (i_sel_valid && (r_state == S_IDLE || w_sel_in_range))
                  w_sel_short = 1'b1;
               if (i_coin_valid) begin
                  if (w_coin_ok) begin
                     w_credit_nx = w_sum[CREDIT_W-1:0];
                     w_state_nx  = S_CREDIT;
                  end else begin
                     w_coin_reject = 1'b1;
                  end
               end
            end
         end
         S_VEND: begin
            w_coin_reject = i_coin_valid;
            w_state_nx    = (r_refund != '0) ? S_CHANGE : S_IDLE;
         end
         default: begin
            w_coin_reject = i_coin_valid;
            w_refund_nx   = r_refund - 1'b1;
            w_state_nx    = (r_refund <= CREDIT_W'(1)) ? S_IDLE : S_CHANGE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_credit      <= '0;
         r_refund      <= '0;
         r_vend_id     <= '0;
         r_coin_reject <= 1'b0;
         r_sel_short   <= 1'b0;
         r_vend_valid  <= 1'b0;
         r_chg5        <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_credit      <= w_credit_nx;
         r_refund      <= w_refund_nx;
         r_vend_id     <= w_vend_id_nx;
         r_coin_reject <= w_coin_reject;
         r_sel_short   <= w_sel_short;
         r_vend_valid  <= w_vend;
         r_chg5        <= (w_state_nx == S_CHANGE);
         r_busy        <= (w_state_nx == S_VEND) || (w_state_nx == S_CHANGE);
      end
   end

   assign o_coin_reject = r_coin_reject;
   assign o_sel_short   = r_sel_short;
   assign o_vend_valid  = r_vend_valid;
   assign o_vend_id     = r_vend_id;
   assign o_chg5        = r_chg5;
   assign o_busy        = r_busy;
   assign o_credit      = r_credit;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb/tb_vend_ctrl_param.sv - directed testbench for vend_ctrl_param
module tb_vend_ctrl_param;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_type = 2'b00;
   logic       sel_valid = 1'b0;
   logic [1:0] sel_id = 2'b00;
   logic       cancel = 1'b0;
   logic       coin_reject, sel_short, vend_valid, chg5, busy;
   logic [1:0] vend_id;
   logic [7:0] credit;

   int n_checks = 0;
   int n_errors = 0;

   vend_ctrl_param dut (
      .clk(clk), .reset(reset),
      .i_coin_valid(coin_valid), .i_coin_type(coin_type),
      .i_sel_valid(sel_valid), .i_sel_id(sel_id), .i_cancel(cancel),
      .o_coin_reject(coin_reject), .o_sel_short(sel_short),
      .o_vend_valid(vend_valid), .o_vend_id(vend_id),
      .o_chg5(chg5), .o_busy(busy), .o_credit(credit)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic cv, input logic [1:0] ct, input logic sv,
                      input logic [1:0] sid, input logic cn);
      coin_valid = cv; coin_type = ct; sel_valid = sv; sel_id = sid; cancel = cn;
      @(posedge clk); #1;
      coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
   endtask

   task automatic coin(input logic [1:0] t); cyc(1'b1, t, 1'b0, 2'd0, 1'b0); endtask
   task automatic sel(input logic [1:0] id); cyc(1'b0, 2'd0, 1'b1, id, 1'b0); endtask
   task automatic idle(); cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0); endtask
   task automatic do_cancel(); cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1); endtask

   task automatic test_reset();
      reset = 1'b1; idle(); idle(); reset = 1'b0;
      n_checks++;
      if ({coin_reject, sel_short, vend_valid, vend_id, chg5, busy, credit} !== 15'd0) begin
         n_errors++;
         $display("FAIL reset_outputs got %b expected all zero",
                  {coin_reject, sel_short, vend_valid, vend_id, chg5, busy, credit});
      end
   endtask

   task automatic test_exact_vend();
      coin(2'b01);
      n_checks++; if (credit !== 8'd2) begin n_errors++; $display("FAIL exact_credit2 got %0d expected 2", credit); end
      coin(2'b00);
      n_checks++; if (credit !== 8'd3) begin n_errors++; $display("FAIL exact_credit3 got %0d expected 3", credit); end
      sel(2'd0);
      n_checks++;
      if ({vend_valid, vend_id, busy, chg5, credit} !== {1'b1, 2'd0, 1'b1, 1'b0, 8'd0}) begin
         n_errors++;
         $display("FAIL exact_vend got v=%b id=%0d busy=%b chg5=%b credit=%0d expected 1 0 1 0 0",
                  vend_valid, vend_id, busy, chg5, credit);
      end
      idle();
      n_checks++;
      if ({vend_valid, busy, chg5} !== 3'b000) begin
         n_errors++; $display("FAIL exact_after got v/busy/chg5=%b expected 000", {vend_valid, busy, chg5});
      end
   endtask

   task automatic test_vend_change();
      coin(2'b10); coin(2'b01);
      n_checks++; if (credit !== 8'd6) begin n_errors++; $display("FAIL change_credit got %0d expected 6", credit); end
      sel(2'd1);
      n_checks++;
      if ({vend_valid, vend_id, busy, chg5} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL change_vend got v=%b id=%0d busy=%b chg5=%b expected 1 1 1 0",
                  vend_valid, vend_id, busy, chg5);
      end
      for (int i = 0; i < 2; i++) begin
         idle();
         n_checks++;
         if ({vend_valid, busy, chg5} !== 3'b011) begin
            n_errors++; $display("FAIL change_pulse%0d got v/busy/chg5=%b expected 011", i, {vend_valid, busy, chg5});
         end
      end
      idle();
      n_checks++;
      if ({busy, chg5, vend_id} !== {1'b0, 1'b0, 2'd1}) begin
         n_errors++; $display("FAIL change_end got busy=%b chg5=%b id=%0d expected 0 0 1", busy, chg5, vend_id);
      end
   endtask

   task automatic test_short_cancel();
      coin(2'b00);
      sel(2'd3);
      n_checks++;
      if ({sel_short, vend_valid, credit} !== {1'b1, 1'b0, 8'd1}) begin
         n_errors++; $display("FAIL short got sel_short=%b v=%b credit=%0d expected 1 0 1", sel_short, vend_valid, credit);
      end
      idle();
      n_checks++; if (sel_short !== 1'b0) begin n_errors++; $display("FAIL short_pulse got %b expected 0", sel_short); end
      do_cancel();
      n_checks++;
      if ({chg5, busy, vend_valid, credit} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
         n_errors++; $display("FAIL cancel got chg5=%b busy=%b v=%b credit=%0d expected 1 1 0 0", chg5, busy, vend_valid, credit);
      end
      idle();
      n_checks++;
      if ({chg5, busy} !== 2'b00) begin n_errors++; $display("FAIL cancel_end got chg5/busy=%b expected 00", {chg5, busy}); end
   endtask

   task automatic test_ceiling();
      int pulses;
      coin(2'b10); coin(2'b10); coin(2'b01);
      n_checks++; if (credit !== 8'd10) begin n_errors++; $display("FAIL ceil_credit10 got %0d expected 10", credit); end
      coin(2'b10);
      n_checks++;
      if ({coin_reject, credit} !== {1'b1, 8'd10}) begin
         n_errors++; $display("FAIL ceil_reject got rej=%b credit=%0d expected 1 10", coin_reject, credit);
      end
      coin(2'b01);
      n_checks++;
      if ({coin_reject, credit} !== {1'b0, 8'd12}) begin
         n_errors++; $display("FAIL ceil_fill got rej=%b credit=%0d expected 0 12", coin_reject, credit);
      end
      do_cancel();
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (chg5) pulses++;
         idle();
      end
      n_checks++;
      if (pulses !== 12 || busy !== 1'b0) begin
         n_errors++; $display("FAIL ceil_refund got %0d pulses busy=%b expected 12 0", pulses, busy);
      end
   endtask

   task automatic test_rejects();
      coin(2'b11);
      n_checks++;
      if ({coin_reject, credit} !== {1'b1, 8'd0}) begin
         n_errors++; $display("FAIL bad_coin got rej=%b credit=%0d expected 1 0", coin_reject, credit);
      end
      coin(2'b01); do_cancel();
      coin(2'b00);
      n_checks++;
      if ({coin_reject, chg5, credit} !== {1'b1, 1'b1, 8'd0}) begin
         n_errors++; $display("FAIL coin_in_change got rej=%b chg5=%b credit=%0d expected 1 1 0", coin_reject, chg5, credit);
      end
      idle();
      coin(2'b00);
      cyc(1'b1, 2'b00, 1'b1, 2'd0, 1'b1);
      n_checks++;
      if ({coin_reject, chg5, vend_valid, sel_short, credit} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
         n_errors++;
         $display("FAIL priority got rej=%b chg5=%b v=%b short=%b credit=%0d expected 1 1 0 0 0",
                  coin_reject, chg5, vend_valid, sel_short, credit);
      end
      idle();
      n_checks++; if ({chg5, busy} !== 2'b00) begin n_errors++; $display("FAIL priority_end got %b expected 00", {chg5, busy}); end
   endtask

   task automatic test_coin_with_short();
      coin(2'b00);
      cyc(1'b1, 2'b01, 1'b1, 2'd2, 1'b0);
      n_checks++;
      if ({sel_short, coin_reject, credit} !== {1'b1, 1'b0, 8'd3}) begin
         n_errors++; $display("FAIL short_coin got short=%b rej=%b credit=%0d expected 1 0 3", sel_short, coin_reject, credit);
      end
      do_cancel(); idle(); idle(); idle();
   endtask

   task automatic test_reset_mid_change();
      coin(2'b10); coin(2'b01);
      sel(2'd0);
      n_checks++;
      if ({vend_valid, busy} !== 2'b11) begin n_errors++; $display("FAIL rst_vend got %b expected 11", {vend_valid, busy}); end
      reset = 1'b1; idle(); reset = 1'b0;
      n_checks++;
      if ({coin_reject, sel_short, vend_valid, vend_id, chg5, busy, credit} !== 15'd0) begin
         n_errors++; $display("FAIL rst_mid got %b expected all zero",
                              {coin_reject, sel_short, vend_valid, vend_id, chg5, busy, credit});
      end
      for (int i = 0; i < 4; i++) begin
         idle();
         n_checks++;
         if ({chg5, busy, credit} !== 10'd0) begin
            n_errors++; $display("FAIL rst_after%0d got chg5=%b busy=%b credit=%0d expected 0 0 0", i, chg5, busy, credit);
         end
      end
   endtask

   initial begin
      test_reset();
      test_exact_vend();
      test_vend_change();
      test_short_cancel();
      test_ceiling();
      test_rejects();
      test_coin_with_short();
      test_reset_mid_change();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vend_ctrl_param.md
# vend_ctrl_param

Parametrised multi-item vending controller with an N-entry price table, three coin denominations, a credit ceiling, user cancel, and serialised change return. Credit is held in 5-unit tokens. Change and refunds are paid as one `chg5` pulse per cycle. The block sits between the coin-acceptor/keypad front end and the dispenser/change-hopper drivers. All outputs are registered (Moore style).

## Interface
- `N_ITEMS`, 4, number of selectable items.
- `CREDIT_W`, 8, width of credit, price and refund counters (5-unit tokens).
- `PRICES`, {8'd6,8'd5,8'd4,8'd3}, packed price table. Item i price is `PRICES[i*CREDIT_W +: CREDIT_W]`. Default prices: item0=3, item1=4, item2=5, item3=6 tokens.
- `MAX_CREDIT`, 12, credit ceiling in tokens.
- `clk` in 1 system clock.
- `reset` in 1 synchronous, active-high.
- `coin_valid` in 1 one-cycle coin strobe.
- `coin_type` in 2 coin value: 00=5, 01=10, 10=20, 11=invalid.
- `sel_valid` in 1 one-cycle item-select strobe.
- `sel_id` in $clog2(N_ITEMS) selected item index.
- `cancel` in 1 one-cycle refund request.
- `coin_reject` out 1 pulse: coin not credited.
- `sel_short` out 1 pulse: selection ignored, credit below price.
- `vend_valid` out 1 pulse: dispense item.
- `vend_id` out $clog2(N_ITEMS) item being dispensed; valid with `vend_valid`.
- `chg5` out 1 pulse: return one 5-unit coin.
- `busy` out 1 high in VEND or CHANGE.
- `credit` out CREDIT_W current credit in tokens.

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Coin token values: 00→1, 01→2, 10→4.
- Coin acceptance: a coin is accepted in IDLE or CREDIT when the type is valid and credit+value ≤ MAX_CREDIT.
  - Accepted: credit += value; IDLE→CREDIT.
  - Otherwise: `coin_reject` pulses and credit is unchanged.
- Any coin presented in VEND or CHANGE is rejected.
- Selection in CREDIT:
  - With `sel_id` < N_ITEMS and credit ≥ price: go to VEND; refund_cnt ← credit−price; credit ← 0.
  - With credit < price: `sel_short` pulses and the state is unchanged.
  - With `sel_id` ≥ N_ITEMS: ignored, no pulse.
- Selection in IDLE with credit 0: `sel_short` pulses.
- VEND lasts exactly 1 cycle. It then goes to CHANGE if refund_cnt>0, else to IDLE.
- Cancel in CREDIT: refund_cnt ← credit; credit ← 0; go to CHANGE. Cancel in IDLE, VEND or CHANGE is ignored.
- CHANGE: `chg5` is asserted every cycle and refund_cnt decrements each cycle. Exit to IDLE on the cycle after the last pulse.
- Same-cycle priority: cancel > sel_valid > coin_valid.
  - A coin in the same cycle as an acted-on cancel or selection is rejected.
  - A coin in the same cycle as an ignored selection (sel_short) is still evaluated normally.
- Arithmetic: compute credit+value at CREDIT_W+1 bits for the ceiling compare. Credit never exceeds MAX_CREDIT, so there is no wrap. refund_cnt is CREDIT_W wide.

## Timing
- Inputs are sampled at posedge clk. Responses are visible in the cycle after the sampling edge (latency 1).
- `coin_reject`, `sel_short`, `vend_valid` and `chg5` are single-cycle pulses. `vend_id` holds its last value otherwise.
- Change of K tokens produces K consecutive `chg5` cycles, starting the cycle after `vend_valid`.
- `busy` is high for 1+K cycles after a vend, and for K cycles after a cancel.
- Reset, including mid-VEND or mid-CHANGE: state is IDLE and credit, refund_cnt and all outputs are 0 on the next cycle. Remaining change is discarded with no further `chg5`.

## Test plan
- Coin 10 then coin 5 (credit=3), then sel 0 → `vend_valid`=1 with `vend_id`=0 for one cycle; zero `chg5`; `busy` high 1 cycle; credit=0; IDLE.
- Coins 20 and 10 (credit=6), then sel 1 (price 4) → `vend_valid` with `vend_id`=1, then exactly 2 consecutive `chg5` pulses; `busy` high 3 cycles.
- Coin 5, then sel 3 → `sel_short` pulse, credit stays 1. Then cancel → exactly 1 `chg5` pulse; no `vend_valid`.
- Coins 20, 20, 10 (credit=10), then coin 20 → `coin_reject` pulse, credit=10. Then coin 10 → credit=12.
- `coin_type`=11 → `coin_reject`. Coin during CHANGE → `coin_reject`. Cancel, sel_valid and coin in the same cycle in CREDIT → refund only; coin rejected.
- Reset asserted while 3 `chg5` pulses remain → next cycle all outputs 0; no further `chg5`; credit=0.
